// File: rtl/frog_ram_ctrl.sv
// Sprite RAM controller: arbitrates CPU writes against a bulk colour fill on the
// write port and serves video pixel fetches (with horizontal mirroring) on the read port.
module frog_ram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2,
    parameter int SPRITE_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_req,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_ack,
    input  logic                        fill_start,
    input  logic [DATA_WIDTH-1:0]       fill_color,
    output logic                        fill_busy,
    output logic                        fill_done,
    input  logic                        pix_req,
    input  logic [$clog2(SPRITE_W)-1:0] pix_x,
    input  logic [$clog2(SPRITE_W)-1:0] pix_y,
    input  logic                        flip_x,
    output logic                        pix_valid,
    output logic [DATA_WIDTH-1:0]       pix_data,
    output logic                        ram_we,
    output logic [ADDR_WIDTH-1:0]       ram_addr_w,
    output logic [DATA_WIDTH-1:0]       ram_din,
    output logic [ADDR_WIDTH-1:0]       ram_addr_r,
    input  logic [DATA_WIDTH-1:0]       ram_dout
);

    localparam int XW = $clog2(SPRITE_W);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  fill_cnt_q;
    logic [DATA_WIDTH-1:0]  fill_color_q;
    logic                   wr_ack_q;
    logic [1:0]             valid_q;
    logic [ADDR_WIDTH-1:0]  addr_r_q;
    logic [XW-1:0]          col_d;
    logic [ADDR_WIDTH-1:0]  addr_r_d;

    // Write-port arbitration: a fill request in IDLE takes priority over a CPU write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fill_cnt_q   <= '0;
            fill_color_q <= '0;
            wr_ack_q     <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        state_q      <= FILL;
                        fill_cnt_q   <= '0;
                        fill_color_q <= fill_color;
                    end else if (wr_req) begin
                        wr_ack_q <= 1'b1;
                    end
                end
                FILL: begin
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                    if (fill_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The RAM write port is driven in the same cycle the write is granted, so it
    // is decoded from the state register and the requests; reset forces it quiet.
    always_comb begin
        ram_we     = 1'b0;
        ram_addr_w = '0;
        ram_din    = '0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (wr_req && !fill_start) begin
                        ram_we     = 1'b1;
                        ram_addr_w = wr_addr;
                        ram_din    = wr_data;
                    end
                end
                FILL: begin
                    ram_we     = 1'b1;
                    ram_addr_w = fill_cnt_q;
                    ram_din    = fill_color_q;
                end
                default: ;
            endcase
        end
    end

    assign wr_ack    = wr_ack_q;
    assign fill_busy = (state_q == FILL);
    assign fill_done = (state_q == DONE);

    // SPRITE_W is a power of two, so the mirrored column is the bitwise inverse
    // and the row offset is a plain concatenation.
    assign col_d    = flip_x ? ~pix_x : pix_x;
    assign addr_r_d = ADDR_WIDTH'({pix_y, col_d});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 2'b00;
            addr_r_q <= '0;
        end else begin
            valid_q <= {valid_q[0], pix_req};
            if (pix_req) begin
                addr_r_q <= addr_r_d;
            end
        end
    end

    assign ram_addr_r = addr_r_q;
    assign pix_valid  = valid_q[1];
    assign pix_data   = valid_q[1] ? ram_dout : '0;

endmodule
